v2_queue_ctrl: RTL and testbench
================================

# v2_queue_ctrl

Control unit that drives the `v2` shift-register FIFO datapath. It terminates a val/rdy enqueue port and a val/rdy dequeue port, and tracks occupancy with a counter. Each cycle it produces the per-entry `wr_data` strobes and `shift_en` codes that the register collection consumes. Entry 0 is the head, so dequeue data is read from `head_data`, which is the datapath's entry-0 output.

## Interface
Parameters:
- `p_depth`, 32, number of datapath entries
- `p_idwidth`, `$clog2(p_depth)`, entry index width
- `p_bitwidth`, 32, message width

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `flush`  in  1  synchronous clear of occupancy
- `enq_val`  in  1  enqueue request
- `enq_rdy`  out  1  enqueue accepted when high with `enq_val`
- `enq_msg`  in  `p_bitwidth`  enqueue data
- `deq_val`  out  1  head valid
- `deq_rdy`  in  1  consumer takes head
- `deq_msg`  out  `p_bitwidth`  head data
- `head_data`  in  `p_bitwidth`  datapath entry-0 contents
- `wr_data`  out  1 x `p_depth`  per-entry write strobe
- `wr_data_in`  out  `p_bitwidth`  write data to datapath; equals `enq_msg`
- `shift_en`  out  2 x `p_depth`  per-entry shift code
- `count`  out  `p_idwidth+1`  current occupancy

## Operation
Datapath codes. `wr_data[i]` has priority over `shift_en[i]`. The `shift_en` codes are:
- 2'b00: hold.
- 2'b01: load from entry i-1 (forward).
- 2'b10: load from entry i+1 (reverse).
- 2'b11 is never driven.

Handshake:
- `enq_fire` = `enq_val & enq_rdy`.
- `deq_fire` = `deq_val & deq_rdy`.
- `enq_rdy` = `!rst & (count != p_depth)`. It never depends combinationally on `deq_rdy`.
- `deq_val` = `!rst & (count != 0)`.
- `deq_msg` = `head_data`.

Per-cycle actions, with k = `count`:
- **Enqueue only:** `wr_data[k]` = 1. All other strobes are 0 and all shift codes are 00.
- **Dequeue only:** `shift_en[i]` = 10 for i in 0..k-2. All other entries hold. Entry k-1 becomes stale and is not cleared.
- **Both (k >= 1):** `shift_en[i]` = 10 for i in 0..k-2, and `wr_data[k-1]` = 1. All other entries hold.
- **Neither:** all strobes 0 and all codes 00.
- The forward code (01) is reserved for later ops and is never issued by this block.

Occupancy:
- `count` +1 on enqueue only, -1 on dequeue only, unchanged on both or neither.
- `count` saturates at neither end, because the handshake makes overflow and underflow impossible.

Occupancy state machine, derived from `count`:
- EMPTY (k=0) to PARTIAL on enqueue only.
- PARTIAL to FULL when enqueue only at k=`p_depth`-1.
- PARTIAL to EMPTY when dequeue only at k=1.
- FULL to PARTIAL on dequeue only.
- FULL with `deq_fire` and no enqueue is legal; enqueue while FULL is impossible because `enq_rdy` is 0.

Flush:
- On `flush`, `count` goes to 0 next cycle.
- All `wr_data` and `shift_en` outputs are forced to 0 during a flush cycle, even if `enq_val`/`deq_rdy` are high.
- `enq_rdy` and `deq_val` remain computed from the current `count`. A handshake that fires in a flush cycle is lost; that is the requirement.

## Timing
- **Reset:** `count` = 0, `enq_rdy` = 0, `deq_val` = 0, all `wr_data` = 0, all `shift_en` = 00. `deq_msg` and `wr_data_in` follow their inputs.
- **Reset mid-operation:** `count` clears at the next edge. Datapath contents are left stale.
- All control outputs are combinational from `count` and the handshake inputs. The only register is `count`.
- **Enqueue latency:** a message accepted at edge N is in entry k after edge N. It appears on `deq_msg` at cycle N+1 if the queue was empty.
- **Dequeue:** effective at the edge where `deq_fire` is high. The next head appears on `deq_msg` in the following cycle.

## Configuration
- `V2_QUEUE_CTRL_BYPASS_EN` defined: adds an empty bypass.
  - When `count` = 0: `deq_val` = `enq_val` and `deq_msg` = `enq_msg`.
  - If `deq_rdy` is also high, the message is consumed directly. No `wr_data` strobe is issued and `count` stays 0.
  - If `deq_rdy` is low, the message is enqueued normally into entry 0.
- Macro undefined: no bypass. Minimum enqueue-to-dequeue latency is 1 cycle, and `deq_val` is low whenever `count` = 0.

## Test plan
- **Reset then idle:** assert `rst` 2 cycles -> `count`=0, `enq_rdy`=0 during reset and 1 after, `deq_val`=0, all strobes 0.
- **Fill to full:** depth 4, enqueue 0xA0..0xA3 with `deq_rdy`=0 -> `wr_data` one-hot at 0,1,2,3 on successive cycles, then `count`=4, `enq_rdy`=0.
- **Drain in order:** continue from full with `deq_rdy`=1 -> `deq_msg` 0xA0,0xA1,0xA2,0xA3. `shift_en`=10 on entries 0..2, then 0..1, then 0, then none. `count` ends at 0 and `deq_val`=0.
- **Simultaneous enq/deq at k=2:** -> `shift_en[0]`=10, `wr_data[1]`=1, `count` stays 2, next head equals the former entry 1.
- **Flush with pending traffic:** `count`=3 with `enq_val`=`deq_rdy`=1 and `flush`=1 -> all strobes 0 that cycle, `count`=0 next cycle.
- **Bypass (macro defined):** empty queue, `enq_val`=`deq_rdy`=1, `enq_msg`=0x5A -> `deq_msg`=0x5A in the same cycle, no strobe, `count` stays 0.

Source files
------------

// File: rtl/v2_queue_ctrl.sv
// ---------------------------------------------------------------------------
// v2_queue_ctrl
//
// Control unit for the v2 shift-register FIFO datapath. Terminates a val/rdy
// enqueue port and a val/rdy dequeue port, keeps the occupancy count, and
// each cycle produces the per-entry write strobes and shift codes that the
// register collection consumes. Entry 0 is the head; dequeue data is taken
// from head_data (the datapath's entry-0 output).
//
// Optional feature:
//   V2_QUEUE_CTRL_BYPASS_EN - when defined, an empty queue passes enq_msg
//   straight to deq_msg; a message consumed that way is never written into
//   the datapath and count stays 0.
//
// Parameters:
//   p_depth     number of datapath entries
//   p_idwidth   entry index width ($clog2(p_depth))
//   p_bitwidth  message width
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   flush        synchronous clear of occupancy (handshakes that cycle are lost)
//   enq_val/rdy  enqueue handshake, enq_msg enqueue data
//   deq_val/rdy  dequeue handshake, deq_msg head data
//   head_data    datapath entry-0 contents
//   wr_data      per-entry write strobe (priority over shift_en)
//   wr_data_in   write data to datapath (= enq_msg)
//   shift_en     per-entry 2-bit shift code, entry i at [2i+1:2i]
//                00 hold, 01 load from i-1 (never issued), 10 load from i+1
//   count        current occupancy
// ---------------------------------------------------------------------------
module v2_queue_ctrl #(
  parameter int p_depth    = 32,
  parameter int p_idwidth  = $clog2(p_depth),
  parameter int p_bitwidth = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    enq_val,
  output logic                    enq_rdy,
  input  logic [p_bitwidth-1:0]   enq_msg,
  output logic                    deq_val,
  input  logic                    deq_rdy,
  output logic [p_bitwidth-1:0]   deq_msg,
  input  logic [p_bitwidth-1:0]   head_data,
  output logic [p_depth-1:0]      wr_data,
  output logic [p_bitwidth-1:0]   wr_data_in,
  output logic [2*p_depth-1:0]    shift_en,
  output logic [p_idwidth:0]      count
);

  typedef logic [p_idwidth:0] cnt_t;

  localparam cnt_t       DEPTH_C = cnt_t'(p_depth);
  localparam cnt_t       ONE_C   = cnt_t'(1);
  // The forward code (01) is reserved for later operations, so only hold
  // and reverse are ever produced here.
  localparam logic [1:0] SH_HOLD = 2'b00;
  localparam logic [1:0] SH_REV  = 2'b10;

  // Occupancy classification; purely a decode of count, not extra state.
  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_e;

  cnt_t count_p0;
  cnt_t count_nxt;
  occ_e occ;

  logic enq_fire;
  logic deq_fire;
  logic bypass_fire;
  logic do_enq;
  logic do_deq;
  logic do_both;

  always_comb begin
    occ = OCC_PARTIAL;
    if (count_p0 == '0) begin
      occ = OCC_EMPTY;
    end else if (count_p0 == DEPTH_C) begin
      occ = OCC_FULL;
    end
  end

  // enq_rdy depends only on occupancy, never on deq_rdy, so a full queue
  // refuses an enqueue even when the consumer is draining that cycle.
  assign enq_rdy    = !rst && (occ != OCC_FULL);
  assign wr_data_in = enq_msg;
  assign count      = count_p0;

`ifdef V2_QUEUE_CTRL_BYPASS_EN
  assign deq_val     = !rst && ((occ != OCC_EMPTY) || enq_val);
  assign deq_msg     = (occ == OCC_EMPTY) ? enq_msg : head_data;
  // Message goes straight through: it must not be written or counted.
  assign bypass_fire = (occ == OCC_EMPTY) && enq_fire && deq_fire;
`else
  assign deq_val     = !rst && (occ != OCC_EMPTY);
  assign deq_msg     = head_data;
  assign bypass_fire = 1'b0;
`endif

  assign enq_fire = enq_val && enq_rdy;
  assign deq_fire = deq_val && deq_rdy;

  // An empty-queue dequeue only exists as a bypass, which always pairs with
  // an enqueue, so do_deq implies count >= 1.
  assign do_enq  = enq_fire && !deq_fire;
  assign do_deq  = deq_fire && !enq_fire;
  assign do_both = enq_fire && deq_fire && !bypass_fire;

  // Datapath strobes. On dequeue every live entry above the head moves one
  // place toward entry 0; on a simultaneous enqueue the new message lands in
  // the slot vacated at the tail (k-1). A dequeue-only leaves entry k-1
  // stale rather than clearing it.
  always_comb begin
    wr_data  = '0;
    shift_en = {p_depth{SH_HOLD}};
    if (!flush) begin
      for (int i = 0; i < p_depth; i++) begin
        if (do_enq && (count_p0 == cnt_t'(i))) begin
          wr_data[i] = 1'b1;
        end
        if ((do_deq || do_both) && ((cnt_t'(i) + ONE_C) < count_p0)) begin
          shift_en[2*i +: 2] = SH_REV;
        end
        if (do_both && ((cnt_t'(i) + ONE_C) == count_p0)) begin
          wr_data[i] = 1'b1;
        end
      end
    end
  end

  // No saturation: the handshake already prevents overflow and underflow.
  always_comb begin
    count_nxt = count_p0;
    if (flush) begin
      count_nxt = '0;
    end else if (do_enq) begin
      count_nxt = count_p0 + ONE_C;
    end else if (do_deq) begin
      count_nxt = count_p0 - ONE_C;
    end
  end

  // ---- stage p0: occupancy register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      count_p0 <= '0;
    end else begin
      count_p0 <= count_nxt;
    end
  end

endmodule

// File: tb/tb_v2_queue_ctrl.sv
module tb_v2_queue_ctrl;

  localparam int DEPTH = 4;
  localparam int IDW   = 2;
  localparam int BW    = 32;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 flush = 1'b0;
  logic                 enq_val = 1'b0;
  logic                 enq_rdy;
  logic [BW-1:0]        enq_msg = '0;
  logic                 deq_val;
  logic                 deq_rdy = 1'b0;
  logic [BW-1:0]        deq_msg;
  logic [BW-1:0]        head_data;
  logic [DEPTH-1:0]     wr_data;
  logic [BW-1:0]        wr_data_in;
  logic [2*DEPTH-1:0]   shift_en;
  logic [IDW:0]         count;

  int n_checks = 0;
  int n_err    = 0;

  v2_queue_ctrl #(
    .p_depth    (DEPTH),
    .p_idwidth  (IDW),
    .p_bitwidth (BW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .enq_val    (enq_val),
    .enq_rdy    (enq_rdy),
    .enq_msg    (enq_msg),
    .deq_val    (deq_val),
    .deq_rdy    (deq_rdy),
    .deq_msg    (deq_msg),
    .head_data  (head_data),
    .wr_data    (wr_data),
    .wr_data_in (wr_data_in),
    .shift_en   (shift_en),
    .count      (count)
  );

  always #5 clk = ~clk;

  // Shift-register datapath driven by the DUT's strobes.
  logic [BW-1:0] dp [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) dp[i] = '0;
  assign head_data = dp[0];

  always @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_data[i]) dp[i] <= wr_data_in;
      else if (shift_en[2*i +: 2] == 2'b01 && i > 0) dp[i] <= dp[i-1];
      else if (shift_en[2*i +: 2] == 2'b10 && i < DEPTH-1) dp[i] <= dp[i+1];
    end
  end

  function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endfunction

  // Reference model: queue contents and the scoreboard of expected deq_msg.
  logic [BW-1:0] mq [$];
  logic [BW-1:0] eq [$];

  int               m_k;
  logic             m_er, m_dv, m_ef, m_df, m_byp;
  logic [DEPTH-1:0] m_ew;
  logic [2*DEPTH-1:0] m_es;

  always @(negedge clk) begin
    m_k  = mq.size();
    m_er = !rst && (m_k != DEPTH);
`ifdef V2_QUEUE_CTRL_BYPASS_EN
    m_dv = !rst && (m_k != 0 || enq_val);
`else
    m_dv = !rst && (m_k != 0);
`endif
    m_ef  = enq_val && m_er;
    m_df  = deq_rdy && m_dv;
    m_byp = m_ef && m_df && (m_k == 0);
    m_ew  = '0;
    m_es  = '0;
    if (!flush && !rst) begin
      if (m_ef && !m_df) m_ew[m_k] = 1'b1;
      if (m_df && !m_byp) begin
        for (int i = 0; i < m_k - 1; i++) m_es[2*i +: 2] = 2'b10;
        if (m_ef) m_ew[m_k-1] = 1'b1;
      end
    end

    chk("count",      64'(count),      64'(m_k));
    chk("enq_rdy",    64'(enq_rdy),    64'(m_er));
    chk("deq_val",    64'(deq_val),    64'(m_dv));
    chk("wr_data",    64'(wr_data),    64'(m_ew));
    chk("shift_en",   64'(shift_en),   64'(m_es));
    chk("wr_data_in", 64'(wr_data_in), 64'(enq_msg));

    if (rst || flush) begin
      mq.delete();
    end else begin
      if (m_df) begin
        if (m_k == 0) eq.push_back(enq_msg);
        else begin
          eq.push_back(mq[0]);
          void'(mq.pop_front());
        end
      end
      if (m_ef && !m_byp) mq.push_back(enq_msg);
    end
  end

  // Monitor: whenever the DUT hands out a message, it must be the next one
  // the scoreboard expects.
  always @(negedge clk) begin
    #2;
    if (!rst && !flush && deq_val && deq_rdy) begin
      if (eq.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL deq_unexpected got=%0h exp=none at %0t", deq_msg, $time);
      end else begin
        chk("deq_msg", 64'(deq_msg), 64'(eq.pop_front()));
      end
    end
  end

  task automatic drive(input bit ev, input logic [BW-1:0] m, input bit dr,
                       input bit fl, input bit r);
    @(posedge clk);
    #1;
    enq_val = ev;
    enq_msg = m;
    deq_rdy = dr;
    flush   = fl;
    rst     = r;
  endtask

  initial begin
    // Reset then idle
    drive(0, 32'h0, 0, 0, 1);
    drive(0, 32'h0, 0, 0, 1);
    drive(0, 32'h0, 0, 0, 0);
    // Fill to full, then an enqueue attempt while full
    for (int i = 0; i < 4; i++) drive(1, 32'hA0 + 32'(i), 0, 0, 0);
    drive(1, 32'hEE, 0, 0, 0);
    // Drain in order
    for (int i = 0; i < 4; i++) drive(0, 32'h0, 1, 0, 0);
    drive(0, 32'h0, 1, 0, 0);
    // Simultaneous enq/deq at k=2
    drive(1, 32'hB0, 0, 0, 0);
    drive(1, 32'hB1, 0, 0, 0);
    drive(1, 32'hB2, 1, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 32'h0, 1, 0, 0);
    // Flush with pending traffic at k=3
    for (int i = 0; i < 3; i++) drive(1, 32'hC0 + 32'(i), 0, 0, 0);
    drive(1, 32'hCC, 1, 1, 0);
    drive(0, 32'h0, 0, 0, 0);
    // Empty queue with both sides active (bypass when enabled)
    drive(1, 32'h5A, 1, 0, 0);
    drive(0, 32'h0, 1, 0, 0);
    drive(0, 32'h0, 0, 0, 0);
    // Randomized traffic with varying enqueue/dequeue bias
    for (int phase = 0; phase < 4; phase++) begin
      for (int n = 0; n < 400; n++) begin
        bit ev, dr, fl, r;
        case (phase)
          0: begin ev = ($urandom_range(0, 3) != 0); dr = ($urandom_range(0, 3) == 0); end
          1: begin ev = ($urandom_range(0, 3) == 0); dr = ($urandom_range(0, 3) != 0); end
          default: begin ev = $urandom_range(0, 1) != 0; dr = $urandom_range(0, 1) != 0; end
        endcase
        fl = ($urandom_range(0, 31) == 0);
        r  = (phase == 3) && ($urandom_range(0, 63) == 0);
        drive(ev, $urandom, dr, fl, r);
      end
    end
    // Drain what is left
    for (int i = 0; i < DEPTH + 2; i++) drive(0, 32'h0, 1, 0, 0);
    drive(0, 32'h0, 0, 0, 0);
    @(posedge clk);
    #8;
    chk("scoreboard_empty", 64'(eq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
